// File: rtl/setbit_frame_accum_if.sv
// setbit_frame_accum_if
//   Stream bundle for setbit_frame_accum: a word input side (valid/ready/data)
//   and a frame-summary output side (valid/ready/total/heavy[/parity]).
//   Parameters N and FRAME_LEN must match the attached block so the derived
//   summary widths agree.
//   Modports:
//     slave  - the accumulator block (consumes words, produces summaries)
//     master - the environment (word source + summary consumer)
//   Optional: out_parity exists only when SETBIT_PARITY_EN is defined.
interface setbit_frame_accum_if #(
  parameter int N         = 4,
  parameter int FRAME_LEN = 4
);
  localparam int TW = $clog2(N*FRAME_LEN+1);
  localparam int FW = $clog2(FRAME_LEN+1);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_total;
  logic [FW-1:0] out_heavy;
`ifdef SETBIT_PARITY_EN
  logic          out_parity;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_total, out_heavy
`ifdef SETBIT_PARITY_EN
    , output out_parity
`endif
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_total, out_heavy
`ifdef SETBIT_PARITY_EN
    , input out_parity
`endif
  );
endinterface

// File: rtl/setbit_frame_accum.sv
// setbit_frame_accum
//   Popcounts each accepted N-bit word (a&(a-1) reduction, combinational),
//   accumulates over frames of FRAME_LEN words and emits a registered summary:
//   total set bits and number of heavy words (popcount > THRESH).
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - asynchronous active-low reset
//     clr    - synchronous clear: drops partial frame and any pending summary
//     bus    - setbit_frame_accum_if.slave (in_* word stream, out_* summary)
//   Optional feature: define SETBIT_PARITY_EN to add out_parity, the XOR of
//   every bit in the frame.
module setbit_frame_accum #(
  parameter int N         = 4,
  parameter int FRAME_LEN = 4,
  parameter int THRESH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  setbit_frame_accum_if.slave   bus
);
  localparam int CW = $clog2(N+1);
  localparam int TW = $clog2(N*FRAME_LEN+1);
  localparam int FW = $clog2(FRAME_LEN+1);
  localparam logic [CW-1:0] THR  = CW'(THRESH);
  localparam logic [FW-1:0] LAST = FW'(FRAME_LEN-1);

  logic [TW-1:0] acc_total;
  logic [FW-1:0] acc_heavy;
  logic [FW-1:0] word_cnt;
  logic [N-1:0]  v;
  logic [CW-1:0] pc;
  logic          heavy;
  logic          accept;
  logic          last;
  logic [TW-1:0] sum_total;
  logic [FW-1:0] sum_heavy;

  // Each iteration strips the lowest set bit; count iterations that found one.
  always_comb begin
    v  = bus.in_data;
    pc = '0;
    for (int i = 0; i < N; i++) begin
      if (v != '0) pc = pc + CW'(1);
      v = v & (v - N'(1));
    end
  end

  assign heavy        = pc > THR;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !clr;
  assign last         = word_cnt == LAST;
  assign sum_total    = acc_total + TW'(pc);
  assign sum_heavy    = acc_heavy + FW'(heavy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_total     <= '0;
      acc_heavy     <= '0;
      word_cnt      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_total <= '0;
      bus.out_heavy <= '0;
    end else if (clr) begin
      // Summary payload is kept; only its valid is dropped.
      acc_total     <= '0;
      acc_heavy     <= '0;
      word_cnt      <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (accept) begin
        if (last) begin
          // Overrides the handshake clear above: back-to-back frames.
          bus.out_total <= sum_total;
          bus.out_heavy <= sum_heavy;
          bus.out_valid <= 1'b1;
          acc_total     <= '0;
          acc_heavy     <= '0;
          word_cnt      <= '0;
        end else begin
          acc_total <= sum_total;
          acc_heavy <= sum_heavy;
          word_cnt  <= word_cnt + FW'(1);
        end
      end
    end
  end

`ifdef SETBIT_PARITY_EN
  logic acc_par;
  logic par_next;

  assign par_next = acc_par ^ (^bus.in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_par        <= 1'b0;
      bus.out_parity <= 1'b0;
    end else if (clr) begin
      acc_par <= 1'b0;
    end else if (accept) begin
      if (last) begin
        bus.out_parity <= par_next;
        acc_par        <= 1'b0;
      end else begin
        acc_par <= par_next;
      end
    end
  end
`endif
endmodule

// File: tb/tb_setbit_frame_accum.sv
// tb_setbit_frame_accum
//   Directed bench: main instance N=4/FRAME_LEN=4/THRESH=2, plus a second
//   instance N=8/FRAME_LEN=1/THRESH=0 for the single-word-frame case.
//   Inputs are driven and outputs sampled 2 time units after the rising edge.
module tb_setbit_frame_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic clr2 = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  setbit_frame_accum_if #(.N(4), .FRAME_LEN(4)) bus ();
  setbit_frame_accum_if #(.N(8), .FRAME_LEN(1)) bus2 ();

  setbit_frame_accum #(.N(4), .FRAME_LEN(4), .THRESH(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus)
  );

  setbit_frame_accum #(.N(8), .FRAME_LEN(1), .THRESH(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .bus(bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Present a word for exactly one edge; in_valid stays high for streaming.
  task automatic send(input logic [3:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    cyc();
  endtask

  task automatic send2(input logic [7:0] w);
    bus2.in_valid = 1'b1;
    bus2.in_data  = w;
    cyc();
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_total", 32'(bus.out_total), 0);
    chk("rst_heavy", 32'(bus.out_heavy), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
`ifdef SETBIT_PARITY_EN
    chk("rst_par", 32'(bus.out_parity), 0);
`endif
    #2 rst_n = 1'b1;
    cyc();

    // 1: basic frame
    send(4'b1100); send(4'b1110); send(4'b0001);
    chk("t1_not_yet", 32'(bus.out_valid), 0);
    send(4'b0000);
    bus.in_valid = 1'b0;
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_total", 32'(bus.out_total), 6);
    chk("t1_heavy", 32'(bus.out_heavy), 1);
`ifdef SETBIT_PARITY_EN
    chk("t1_par", 32'(bus.out_parity), 0);
`endif
    cyc();
    chk("t1_consumed", 32'(bus.out_valid), 0);

    // 2: back-to-back frames, no bubble
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_ready_a", 32'(bus.in_ready), 1);
      send(4'b1111);
    end
    chk("t2_valid_a", 32'(bus.out_valid), 1);
    chk("t2_total_a", 32'(bus.out_total), 16);
    chk("t2_heavy_a", 32'(bus.out_heavy), 4);
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_ready_b", 32'(bus.in_ready), 1);
      send(4'b0000);
      if (i == 0) chk("t2_gap", 32'(bus.out_valid), 0);
    end
    bus.in_valid = 1'b0;
    chk("t2_valid_b", 32'(bus.out_valid), 1);
    chk("t2_total_b", 32'(bus.out_total), 0);
    chk("t2_heavy_b", 32'(bus.out_heavy), 0);
    cyc();

    // 3: back-pressure holds the summary and blocks input
    bus.out_ready = 1'b0;
    send(4'b1100); send(4'b1110); send(4'b0001); send(4'b0000);
    bus.in_data = 4'b1111;
    #1;
    chk("t3_ready_lo", 32'(bus.in_ready), 0);
    cyc(); cyc();
    chk("t3_hold_valid", 32'(bus.out_valid), 1);
    chk("t3_hold_total", 32'(bus.out_total), 6);
    chk("t3_hold_heavy", 32'(bus.out_heavy), 1);
    chk("t3_ready_hold", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    #1 chk("t3_ready_hi", 32'(bus.in_ready), 1);
    cyc();  // summary taken and first 1111 accepted on the same edge
    chk("t3_taken", 32'(bus.out_valid), 0);
    send(4'b1111); send(4'b1111); send(4'b1111);
    bus.in_valid = 1'b0;
    chk("t3_f2_valid", 32'(bus.out_valid), 1);
    chk("t3_f2_total", 32'(bus.out_total), 16);
    chk("t3_f2_heavy", 32'(bus.out_heavy), 4);
    cyc();

    // 4: async reset mid-frame
    send(4'b1111); send(4'b1111);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", 32'(bus.out_valid), 0);
    chk("t4_rst_total", 32'(bus.out_total), 0);
    chk("t4_rst_heavy", 32'(bus.out_heavy), 0);
    #1 rst_n = 1'b1;
    cyc();
    send(4'b0001); send(4'b0011); send(4'b0111); send(4'b1111);
    bus.in_valid = 1'b0;
    chk("t4_valid", 32'(bus.out_valid), 1);
    chk("t4_total", 32'(bus.out_total), 10);
    chk("t4_heavy", 32'(bus.out_heavy), 2);
`ifdef SETBIT_PARITY_EN
    chk("t4_par", 32'(bus.out_parity), 0);
`endif
    cyc();

    // 5: clr drops the partial frame and the word offered with it
    send(4'b0001); send(4'b0001);
    clr = 1'b1;
    send(4'b1111);
    clr = 1'b0;
    chk("t5_clr_valid", 32'(bus.out_valid), 0);
    chk("t5_clr_keep", 32'(bus.out_total), 10);
    for (int i = 0; i < 4; i++) send(4'b0111);
    bus.in_valid = 1'b0;
    chk("t5_valid", 32'(bus.out_valid), 1);
    chk("t5_total", 32'(bus.out_total), 12);
    chk("t5_heavy", 32'(bus.out_heavy), 4);
`ifdef SETBIT_PARITY_EN
    chk("t5_par", 32'(bus.out_parity), 0);
`endif
    cyc();

    // 6: FRAME_LEN=1 instance, one summary per word
    send2(8'h00);
    chk("t6_valid_a", 32'(bus2.out_valid), 1);
    chk("t6_total_a", 32'(bus2.out_total), 0);
    chk("t6_heavy_a", 32'(bus2.out_heavy), 0);
    send2(8'hFF);
    bus2.in_valid = 1'b0;
    chk("t6_valid_b", 32'(bus2.out_valid), 1);
    chk("t6_total_b", 32'(bus2.out_total), 8);
    chk("t6_heavy_b", 32'(bus2.out_heavy), 1);
    cyc();
    chk("t6_consumed", 32'(bus2.out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
